// File: rtl/dnn_layer_seq_if.sv
// dnn_layer_seq_if: handshake and weight-programming bundle for dnn_layer_seq.
//   in_valid/in_ready/x_flat        input vector, element i at [i*XW +: XW]
//   w_wr_en/w_wr_addr/w_wr_data     weight write port, index = j*N_IN + i
//   out_valid/out_ready/out_flat    result vector, output j at [j*OW +: OW]
//   busy                            block is computing or holding a result
// modport slave is the layer itself; modport master is whoever drives it.
interface dnn_layer_seq_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int XW    = 17,
  parameter int WW    = 5,
  parameter int OW    = 17
);
  localparam int NW  = N_IN * N_OUT;
  localparam int AWD = $clog2(NW);

  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN*XW-1:0]      x_flat;
  logic                    w_wr_en;
  logic [AWD-1:0]          w_wr_addr;
  logic signed [WW-1:0]    w_wr_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_OUT*OW-1:0]     out_flat;
  logic                    busy;

  modport master (
    output in_valid, x_flat, w_wr_en, w_wr_addr, w_wr_data, out_ready,
    input  in_ready, out_valid, out_flat, busy
  );

  modport slave (
    input  in_valid, x_flat, w_wr_en, w_wr_addr, w_wr_data, out_ready,
    output in_ready, out_valid, out_flat, busy
  );
endinterface

// File: rtl/dnn_layer_seq.sv
// dnn_layer_seq: time-multiplexed fully-connected layer.
// Accepts one N_IN-element signed vector, walks the inputs one per cycle with
// one MAC lane per output, saturates each sum to OW bits and holds the result
// until the downstream handshake completes.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (aborts any vector in flight)
//   bus   dnn_layer_seq_if.slave (input vector, weight writes, result, busy)
// Build option: DNN_RELU_EN -- when defined, negative saturated results are
// clamped to zero before being registered.

// One output lane: accumulator plus saturation of the running sum.
module dnn_mac_lane #(
  parameter int XW = 17,
  parameter int WW = 5,
  parameter int OW = 17,
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [XW-1:0] x,
  input  logic signed [WW-1:0] w,
  output logic        [OW-1:0] res
);
  localparam logic signed [AW-1:0] MAXV = AW'({(OW-1){1'b1}});
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    sum;
  logic signed [XW+WW-1:0] prod;
  logic signed [OW-1:0]    sat;

  assign prod = x * w;
  // sum includes the current product so the last MAC cycle can register it
  assign sum  = acc + AW'(prod);

  always_comb begin
    sat = sum[OW-1:0];
    if (sum > MAXV)      sat = MAXV[OW-1:0];
    else if (sum < MINV) sat = MINV[OW-1:0];
  end

`ifdef DNN_RELU_EN
  assign res = sat[OW-1] ? '0 : sat;
`else
  assign res = sat;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= sum;
  end
endmodule

module dnn_layer_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int XW    = 17,
  parameter int WW    = 5,
  parameter int OW    = 17
) (
  input logic           clk,
  input logic           rst,
  dnn_layer_seq_if.slave bus
);
  localparam int NW = N_IN * N_OUT;
  localparam int AW = XW + WW + $clog2(N_IN);
  localparam int IW = $clog2(N_IN);

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t                    state;
  logic [IW-1:0]             idx;
  logic [N_IN*XW-1:0]        x_reg;
  logic signed [WW-1:0]      w_mem [NW];
  logic [N_OUT-1:0][OW-1:0]  res;
  logic signed [XW-1:0]      x_cur;
  logic                      accept;
  logic                      last;
  logic                      mac_en;

  assign bus.in_ready = (state == IDLE) && !rst;
  assign bus.busy     = (state != IDLE);

  assign accept = bus.in_valid && bus.in_ready;
  assign mac_en = (state == MAC);
  assign last   = mac_en && (idx == IW'(N_IN - 1));
  assign x_cur  = x_reg[idx*XW +: XW];

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    dnn_mac_lane #(.XW(XW), .WW(WW), .OW(OW), .AW(AW)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (mac_en),
      .x   (x_cur),
      .w   (w_mem[j*N_IN + int'(idx)]),
      .res (res[j])
    );
  end

  // Weights only change while idle; a write coinciding with acceptance lands
  // before the first MAC cycle reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) w_mem[i] <= '0;
    end else if (bus.w_wr_en && state == IDLE && 32'(bus.w_wr_addr) < NW) begin
      w_mem[bus.w_wr_addr] <= bus.w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      x_reg         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_flat  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x_reg <= bus.x_flat;
          idx   <= '0;
          state <= MAC;
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (last) begin
            idx           <= '0;
            bus.out_flat  <= res;
            bus.out_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dnn_layer_seq.sv
module tb_dnn_layer_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dnn_layer_seq_if bus ();

  dnn_layer_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] out_j(input int j);
    logic signed [16:0] v;
    v = bus.out_flat[j*17 +: 17];
    return 32'(v);
  endfunction

  function automatic logic [67:0] pack(input int a, input int b, input int c, input int d);
    return {17'(d), 17'(c), 17'(b), 17'(a)};
  endfunction

  task automatic wr(input int addr, input int data);
    bus.w_wr_en   = 1'b1;
    bus.w_wr_addr = 3'(addr);
    bus.w_wr_data = 5'(data);
    tick();
    bus.w_wr_en   = 1'b0;
  endtask

  task automatic wr_all(input int w0, input int w1, input int w2, input int w3,
                        input int w4, input int w5, input int w6, input int w7);
    wr(0, w0); wr(1, w1); wr(2, w2); wr(3, w3);
    wr(4, w4); wr(5, w5); wr(6, w6); wr(7, w7);
  endtask

  // Present a vector for one cycle (block must be idle) and wait for out_valid.
  task automatic run_vec(input string tag, input int a, input int b, input int c,
                         input int d);
    int lat;
    bus.x_flat   = pack(a, b, c, d);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
    check({tag, "_ready_back"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    logic [33:0] held;
    int          seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_flat    = '0;
    bus.w_wr_en   = 1'b0;
    bus.w_wr_addr = '0;
    bus.w_wr_data = '0;
    bus.out_ready = 1'b0;
    tick(); tick(); tick();

    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_flat", 32'(bus.out_flat), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 1);

    // Basic vector with busy/in_ready observed during MAC.
    wr_all(1, 2, 3, 4, -1, -1, -1, -1);
    bus.x_flat   = pack(10, 20, 30, 40);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("mac_busy", 32'(bus.busy), 1);
    check("mac_in_ready", 32'(bus.in_ready), 0);
    tick(); tick(); tick();
    check("mac_no_early_valid", 32'(bus.out_valid), 0);
    tick();
    check("basic_valid_at_4", 32'(bus.out_valid), 1);
    check("basic_out0", out_j(0), 300);
`ifdef DNN_RELU_EN
    check("basic_out1", out_j(1), 0);
`else
    check("basic_out1", out_j(1), -100);
`endif

    // Backpressure: hold 5 cycles with a competing input vector offered.
    held = bus.out_flat;
    bus.x_flat   = pack(1, 1, 1, 1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_flat_stable", 32'(bus.out_flat != held), 0);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_valid_held", 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    handshake("bp");
    check("bp_idle_not_busy", 32'(bus.busy), 0);

    // Writes during MAC and HOLD must be dropped; result unchanged.
    bus.x_flat   = pack(10, 20, 30, 40);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.w_wr_en   = 1'b1;
    bus.w_wr_addr = 3'd0;
    bus.w_wr_data = 5'd7;
    seen = 0;
    while (!bus.out_valid && seen < 20) begin
      tick();
      seen++;
    end
    check("wg_latency", seen, 4);
    tick();
    bus.w_wr_addr = 3'd4;
    tick();
    bus.w_wr_en = 1'b0;
    check("wg_out0", out_j(0), 300);
    handshake("wg");
    run_vec("wg2", 10, 20, 30, 40);
    check("wg2_out0", out_j(0), 300);
`ifdef DNN_RELU_EN
    check("wg2_out1", out_j(1), 0);
`else
    check("wg2_out1", out_j(1), -100);
`endif
    handshake("wg2");

    // Saturation at both rails.
    wr_all(15, 15, 15, 15, 15, 15, 15, 15);
    run_vec("satp", 65535, 65535, 65535, 65535);
    check("satp_out0", out_j(0), 65535);
    check("satp_out1", out_j(1), 65535);
    handshake("satp");
    wr_all(-16, -16, -16, -16, -16, -16, -16, -16);
    run_vec("satn", 65535, 65535, 65535, 65535);
`ifdef DNN_RELU_EN
    check("satn_out0", out_j(0), 0);
    check("satn_out1", out_j(1), 0);
`else
    check("satn_out0", out_j(0), -65536);
    check("satn_out1", out_j(1), -65536);
`endif
    handshake("satn");

    // Exact edge: 65535 passes, 65536 clips; -65536 passes, -65537 clips.
    wr_all(1, 0, 0, 0, 1, 1, 0, 0);
    run_vec("edgep", 65535, 1, 0, 0);
    check("edgep_out0", out_j(0), 65535);
    check("edgep_out1", out_j(1), 65535);
    handshake("edgep");
`ifndef DNN_RELU_EN
    run_vec("edgen", -65536, -1, 0, 0);
    check("edgen_out0", out_j(0), -65536);
    check("edgen_out1", out_j(1), -65536);
    handshake("edgen");
`endif

    // Reset two cycles into MAC aborts the vector and clears weights.
    wr_all(1, 2, 3, 4, -1, -1, -1, -1);
    bus.x_flat   = pack(10, 20, 30, 40);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("abort_no_valid", seen, 0);
    check("abort_idle", 32'(bus.busy), 0);
    run_vec("zw", 5, 5, 5, 5);
    check("zw_out0", out_j(0), 0);
    check("zw_out1", out_j(1), 0);
    handshake("zw");

    // A write in the acceptance cycle is used by that vector.
    bus.x_flat    = pack(5, 5, 5, 5);
    bus.in_valid  = 1'b1;
    bus.w_wr_en   = 1'b1;
    bus.w_wr_addr = 3'd4;
    bus.w_wr_data = 5'd3;
    tick();
    bus.in_valid = 1'b0;
    bus.w_wr_en  = 1'b0;
    seen = 0;
    while (!bus.out_valid && seen < 20) begin
      tick();
      seen++;
    end
    check("same_cyc_latency", seen, 4);
    check("same_cyc_out0", out_j(0), 0);
    check("same_cyc_out1", out_j(1), 15);
    handshake("same_cyc");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
